// File: rtl/clock_enable_gen_if.sv
// Configuration/sync inputs and divided clock/strobe outputs of clock_enable_gen.
// The master side drives writes and sync, and the slave side is the divider itself.
interface clock_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
);
  logic              sync;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] cfg_pending;

  modport master (
    output sync, cfg_wr, cfg_ch, cfg_div,
    input  clk_out, en_out, cfg_pending
  );

  modport slave (
    input  sync, cfg_wr, cfg_ch, cfg_div,
    output clk_out, en_out, cfg_pending
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock divider with per-channel rise strobes.
// Divisor changes on a running channel wait for the end of the current period.
module clock_enable_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_RESET = {8'd0, 8'd0, 8'd2, 8'd1}
) (
  input logic               clock,
  input logic               reset,
  clock_enable_gen_if.slave bus
);

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] en_vec;
  logic [NUM_CH-1:0] pend_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic             clk_q;
    logic             en_q;
    logic             pend_v;
    logic             wr_hit;
    logic             terminal;

    // Out-of-range channel indices never match, so such writes are dropped.
    assign wr_hit   = bus.cfg_wr && (bus.cfg_ch == CH_W'(i));
    assign terminal = (cnt == div_act - CNT_W'(1));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt      <= '0;
        clk_q    <= 1'b0;
        en_q     <= 1'b0;
        pend_v   <= 1'b0;
        div_pend <= '0;
        div_act  <= DIV_RESET[i*CNT_W +: CNT_W];
      end else if (bus.sync) begin
        cnt   <= '0;
        clk_q <= 1'b0;
        en_q  <= 1'b0;
        if (wr_hit) begin
          div_act <= bus.cfg_div;
          pend_v  <= 1'b0;
        end else if (pend_v) begin
          div_act <= div_pend;
          pend_v  <= 1'b0;
        end
      end else if (div_act == '0) begin
        cnt   <= '0;
        clk_q <= 1'b0;
        en_q  <= 1'b0;
        if (wr_hit) begin
          div_act <= bus.cfg_div;
        end
      end else begin
        if (terminal) begin
          cnt   <= '0;
          clk_q <= ~clk_q;
          en_q  <= ~clk_q;
          // Only the falling toggle closes a full period, so swap divisors there.
          if (clk_q && pend_v) begin
            div_act <= div_pend;
            pend_v  <= 1'b0;
          end
        end else begin
          cnt  <= cnt + CNT_W'(1);
          en_q <= 1'b0;
        end
        // A write landing on the boundary queues behind the divisor just applied.
        if (wr_hit) begin
          div_pend <= bus.cfg_div;
          pend_v   <= 1'b1;
        end
      end
    end

    assign clk_vec[i]  = clk_q;
    assign en_vec[i]   = en_q;
    assign pend_vec[i] = pend_v;
  end

  assign bus.clk_out     = clk_vec;
  assign bus.en_out      = en_vec;
  assign bus.cfg_pending = pend_vec;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: a cycle table for the basic and reconfiguration
// behaviour, then hand sequences for sync, asynchronous reset and out-of-range writes.
module tb_clock_enable_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  clock_enable_gen_if #(.NUM_CH(4), .CNT_W(8), .CH_W(2)) bus ();
  clock_enable_gen_if #(.NUM_CH(3), .CNT_W(8), .CH_W(2)) bus3 ();

  clock_enable_gen #(
    .NUM_CH(4), .CNT_W(8), .CH_W(2),
    .DIV_RESET({8'd0, 8'd0, 8'd2, 8'd1})
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  clock_enable_gen #(
    .NUM_CH(3), .CNT_W(8), .CH_W(2),
    .DIV_RESET({8'd0, 8'd2, 8'd1})
  ) dut3 (
    .clock(clock),
    .reset(reset),
    .bus  (bus3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       sync;
    logic       wr;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] exp_clk;
    logic [3:0] exp_en;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic s, logic w, logic [1:0] c, logic [7:0] d,
                              logic [3:0] ck, logic [3:0] en, logic [3:0] pd);
    vec_t v;
    v.sync = s; v.wr = w; v.ch = c; v.div = d;
    v.exp_clk = ck; v.exp_en = en; v.exp_pend = pd;
    return v;
  endfunction

  // j counts rising edges since all counters were cleared (reset release or sync).
  function automatic logic [3:0] model_vec(int j, int d0, int d1, int d2, int d3, bit strobe);
    int d[4];
    logic [3:0] r;
    d = '{d0, d1, d2, d3};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      if (d[c] != 0) begin
        if (strobe) r[c] = ((j % d[c]) == 0) && (((j / d[c]) % 2) == 1);
        else        r[c] = (((j / d[c]) % 2) == 1);
      end
    end
    return r;
  endfunction

  task automatic apply_stimulus(logic s, logic w, logic [1:0] c, logic [7:0] d);
    bus.sync    = s;
    bus.cfg_wr  = w;
    bus.cfg_ch  = c;
    bus.cfg_div = d;
  endtask

  task automatic check_output(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] m_clk;
    logic [3:0] m_en;

    vecs[0]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 4'b0000);
    vecs[1]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    vecs[2]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0011, 4'b0001, 4'b0000);
    vecs[3]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[4]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 4'b0000);
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    vecs[6]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0011, 4'b0001, 4'b0000);
    vecs[7]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[8]  = mk(1'b0, 1'b1, 2'd2, 8'd3, 4'b0001, 4'b0001, 4'b0000);
    vecs[9]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    vecs[10] = mk(1'b0, 1'b1, 2'd1, 8'd5, 4'b0011, 4'b0001, 4'b0010);
    vecs[11] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0100, 4'b0100, 4'b0000);
    vecs[12] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0101, 4'b0001, 4'b0000);
    vecs[13] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0100, 4'b0000, 4'b0000);
    vecs[14] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 4'b0000);
    vecs[15] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[16] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0011, 4'b0011, 4'b0000);
    vecs[17] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0110, 4'b0100, 4'b0000);
    vecs[18] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0111, 4'b0001, 4'b0000);
    vecs[19] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0110, 4'b0000, 4'b0000);
    vecs[20] = mk(1'b0, 1'b1, 2'd0, 8'd0, 4'b0011, 4'b0001, 4'b0001);
    vecs[21] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[22] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[23] = mk(1'b0, 1'b0, 2'd0, 8'd0, 4'b0100, 4'b0100, 4'b0000);

    apply_stimulus(1'b0, 1'b0, 2'd0, 8'd0);
    bus3.sync = 1'b0; bus3.cfg_wr = 1'b0; bus3.cfg_ch = 2'd0; bus3.cfg_div = 8'd0;

    @(negedge clock);
    @(negedge clock);
    check_output("reset clk_out", bus.clk_out, 4'b0000);
    check_output("reset en_out", bus.en_out, 4'b0000);
    check_output("reset cfg_pending", bus.cfg_pending, 4'b0000);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].sync, vecs[i].wr, vecs[i].ch, vecs[i].div);
      @(negedge clock);
      check_output($sformatf("row%0d clk_out", i), bus.clk_out, vecs[i].exp_clk);
      check_output($sformatf("row%0d en_out", i), bus.en_out, vecs[i].exp_en);
      check_output($sformatf("row%0d cfg_pending", i), bus.cfg_pending, vecs[i].exp_pend);
    end

    // ch3 disabled gets D=4 directly, ch1 queues D=2, then sync with a bypass write of D=6 to ch2.
    apply_stimulus(1'b0, 1'b1, 2'd3, 8'd4);
    @(negedge clock);
    apply_stimulus(1'b0, 1'b1, 2'd1, 8'd2);
    @(negedge clock);
    check_output("pre-sync cfg_pending", bus.cfg_pending, 4'b0010);
    apply_stimulus(1'b1, 1'b1, 2'd2, 8'd6);
    @(negedge clock);
    check_output("sync cfg_pending", bus.cfg_pending, 4'b0000);
    check_output("sync j0 clk_out", bus.clk_out, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 2'd0, 8'd0);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clock);
      m_clk = model_vec(j, 0, 2, 6, 4, 1'b0);
      m_en  = model_vec(j, 0, 2, 6, 4, 1'b1);
      check_output($sformatf("sync j%0d clk_out", j), bus.clk_out, m_clk);
      check_output($sformatf("sync j%0d en_out", j), bus.en_out, m_en);
    end

    // Queue a divisor on ch1, then reset mid-period; the queued value must be lost.
    apply_stimulus(1'b0, 1'b1, 2'd1, 8'd7);
    @(negedge clock);
    apply_stimulus(1'b0, 1'b0, 2'd0, 8'd0);
    check_output("pre-reset cfg_pending", bus.cfg_pending, 4'b0010);
    @(negedge clock);
    check_output("pre-reset clk_out", bus.clk_out, model_vec(18, 0, 2, 6, 4, 1'b0));
    reset = 1'b1;
    #1;
    check_output("async reset clk_out", bus.clk_out, 4'b0000);
    check_output("async reset en_out", bus.en_out, 4'b0000);
    check_output("async reset cfg_pending", bus.cfg_pending, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      m_clk = model_vec(k, 1, 2, 0, 0, 1'b0);
      m_en  = model_vec(k, 1, 2, 0, 0, 1'b1);
      check_output($sformatf("post-reset k%0d clk_out", k), bus.clk_out, m_clk);
      check_output($sformatf("post-reset k%0d en_out", k), bus.en_out, m_en);
      check_output($sformatf("post-reset k%0d cfg_pending", k), bus.cfg_pending, 4'b0000);
    end

    // Three-channel instance: a write to index 3 has no channel to land on.
    bus3.cfg_wr = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_div = 8'd3;
    for (int k = 9; k <= 16; k++) begin
      @(negedge clock);
      bus3.cfg_wr = 1'b0;
      m_clk = model_vec(k, 1, 2, 0, 0, 1'b0);
      check_output($sformatf("ch3-ignored k%0d clk_out", k), {1'b0, bus3.clk_out}, m_clk);
      check_output($sformatf("ch3-ignored k%0d cfg_pending", k), {1'b0, bus3.cfg_pending}, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
